// File: rtl/noc_pe_interface.sv
// PE-side network interface: TX turns one neuron result into one flit per fan-out destination,
// RX checks and buffers flits ejected by the switch. Optional macro: NI_DEST_CHECK_EN.
module noc_pe_interface #(
  parameter int X_COORD    = 0,
  parameter int Y_COORD    = 0,
  parameter int DATA_WIDTH = 8,
  parameter int X_SIZE     = 2,
  parameter int Y_SIZE     = 2,
  parameter int NUM_DEST   = 4,
  parameter int RX_DEPTH   = 4,
  parameter int FW         = 2*X_SIZE+2*Y_SIZE+DATA_WIDTH,
  parameter int CW         = $clog2(NUM_DEST+1)
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              tx_valid,
  input  logic [DATA_WIDTH-1:0]             tx_data,
  output logic                              tx_ready,
  output logic                              tx_done,
  input  logic [NUM_DEST*(X_SIZE+Y_SIZE)-1:0] dest_list,
  input  logic [CW-1:0]                     dest_count,
  output logic                              o_valid_sw,
  output logic [FW-1:0]                     o_data_sw,
  input  logic                              i_ready_sw,
  input  logic                              i_valid_sw,
  input  logic [FW-1:0]                     i_data_sw,
  output logic                              o_ready_sw,
  output logic                              rx_valid,
  output logic [DATA_WIDTH-1:0]             rx_data,
  output logic [X_SIZE-1:0]                 rx_src_x,
  output logic [Y_SIZE-1:0]                 rx_src_y,
  input  logic                              rx_ready,
  output logic [7:0]                        rx_drop_cnt
);

  // Every channel transfers exactly one item on a cycle where valid and ready are both high;
  // a valid producer holds valid and data steady until that cycle.
  localparam int EW = X_SIZE + Y_SIZE;
  localparam int AW = $clog2(RX_DEPTH);
  localparam int RW = DATA_WIDTH + EW;
  localparam logic [EW-1:0] SRC = {X_SIZE'(X_COORD), Y_SIZE'(Y_COORD)};

  typedef enum logic {IDLE, SEND} tx_state_e;

  tx_state_e             state_q, state_d;
  logic [CW-1:0]         idx_q, idx_d, cnt_q, cnt_d, cnt_in, idx_nxt;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d, done_q, done_d;
  logic [FW-1:0]         flit_q, flit_d;

  function automatic logic [FW-1:0] make_flit(input logic [EW-1:0] dest,
                                              input logic [DATA_WIDTH-1:0] pl);
    return {pl, SRC, dest};
  endfunction

  assign cnt_in  = (dest_count > CW'(NUM_DEST)) ? CW'(NUM_DEST) : dest_count;
  assign idx_nxt = idx_q + CW'(1);

  // tx_ready stays low during the tx_done cycle so a new result starts strictly after it.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = valid_q;
    flit_d   = flit_q;
    done_d   = 1'b0;
    tx_ready = 1'b0;
    case (state_q)
      IDLE: begin
        tx_ready = ~done_q;
        if (tx_valid && !done_q) begin
          data_d = tx_data;
          cnt_d  = cnt_in;
          idx_d  = '0;
          if (cnt_in == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = SEND;
            valid_d = 1'b1;
            flit_d  = make_flit(dest_list[0 +: EW], tx_data);
          end
        end
      end
      SEND: begin
        if (i_ready_sw) begin
          if (idx_q < cnt_q - CW'(1)) begin
            idx_d  = idx_nxt;
            flit_d = make_flit(dest_list[int'(idx_nxt)*EW +: EW], data_q);
          end else begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      flit_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      flit_q  <= flit_d;
      done_q  <= done_d;
    end
  end

  assign o_valid_sw = valid_q;
  assign o_data_sw  = flit_q;
  assign tx_done    = done_q;

  logic [RW-1:0] mem_q [RX_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          dest_ok, accept, push, pop;
  logic [RW-1:0] head;

`ifdef NI_DEST_CHECK_EN
  assign dest_ok = (i_data_sw[EW-1:0] == SRC);
`else
  logic unused_dest;
  assign unused_dest = ^i_data_sw[EW-1:0];
  assign dest_ok     = 1'b1;
`endif

  assign o_ready_sw = (count_q != (AW+1)'(RX_DEPTH));
  assign rx_valid   = (count_q != '0);
  assign accept     = i_valid_sw & o_ready_sw;
  assign push       = accept & dest_ok;
  assign pop        = rx_valid & rx_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (!push && pop) count_q <= count_q - (AW+1)'(1);
    end
  end

  // Only payload and source travel through the FIFO; the destination is already consumed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {i_data_sw[FW-1 -: DATA_WIDTH], i_data_sw[2*EW-1:EW]};
  end

  assign head     = mem_q[rptr_q];
  assign rx_data  = head[RW-1 -: DATA_WIDTH];
  assign rx_src_x = head[EW-1:Y_SIZE];
  assign rx_src_y = head[Y_SIZE-1:0];

`ifdef NI_DEST_CHECK_EN
  logic [7:0] drop_q;
  always_ff @(posedge clk) begin
    if (!rstn)                                 drop_q <= '0;
    else if (accept && !dest_ok && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
  end
  assign rx_drop_cnt = drop_q;
`else
  assign rx_drop_cnt = 8'd0;
`endif

endmodule
